// File: rtl/mem_access_unit.sv
// Load/store unit for a word-organised data memory. Sub-word stores are done as
// read-modify-write. Sub-word loads are lane-selected and then zero- or sign-extended.
module mem_access_unit #(
  parameter int unsigned DEPTH_LOG2 = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_Address,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_Data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] memw_q, memw_d;
  logic [1:0]  size_q;
  logic        signed_q, write_q, error_q;
  logic        accept, acc_error;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, merged;

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    acc_error = 1'b0;
    if (req_size == 2'b11) begin
      acc_error = 1'b1;
    end else if (req_size == 2'b01 && req_addr[0]) begin
      acc_error = 1'b1;
    end else if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
      acc_error = 1'b1;
    end else if ({1'b0, req_addr[31:2]} >= (31'd1 << DEPTH_LOG2)) begin
      acc_error = 1'b1;
    end
  end

  // Little-endian lane selection from the captured address.
  always_comb begin
    lane_b   = mem_Data[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = mem_Data[{addr_q[1], 4'b0000} +: 16];
    load_val = mem_Data;
    if (size_q == 2'b00) begin
      load_val = {{24{signed_q & lane_b[7]}}, lane_b};
    end else if (size_q == 2'b01) begin
      load_val = {{16{signed_q & lane_h[15]}}, lane_h};
    end
  end

  always_comb begin
    merged = mem_Data;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    memw_d  = memw_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = '0;
          if (acc_error) begin
            state_d = StResp;
          end else if (req_write && req_size == 2'b10) begin
            memw_d  = req_wdata;
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        // Only sub-word stores and loads reach RD.
        if (write_q) begin
          memw_d  = merged;
          state_d = StWr;
        end else begin
          rdata_d = load_val;
          state_d = StResp;
        end
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
      memw_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      memw_q  <= memw_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
        error_q  <= acc_error;
      end
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign resp_valid    = (state_q == StResp);
  assign resp_rdata    = rdata_q;
  assign resp_error    = error_q;
  assign mem_Address   = {2'b00, addr_q[31:2]};
  assign mem_MemRead   = (state_q == StRd);
  assign mem_MemWrite  = (state_q == StWr);
  assign mem_WriteData = memw_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a behavioural 8K-word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_Address, mem_WriteData, mem_Data;
  logic        mem_MemRead, mem_MemWrite;

  logic [31:0] mem [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_idx = '0;
  logic [31:0] bd_val = '0;
  int          wr_count = 0;

  int vectors = 0;
  int miscompares = 0;

  // Per-transaction observations gathered by run_req.
  int          lat, nrd, nwr, rd_cyc, wr_cyc, both, busy_ready;
  logic [31:0] rd_addr, wr_data, rdata;
  logic        err, after_valid, after_ready;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_LOG2(13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_Address  (mem_Address),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_WriteData(mem_WriteData),
    .mem_Data     (mem_Data)
  );

  assign mem_Data = mem[mem_Address[12:0]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_val;
    if (mem_MemWrite) begin
      mem[mem_Address[12:0]] <= mem_WriteData;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [12:0] idx, input logic [31:0] v);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = idx;
    bd_val = v;
    @(negedge clk);
    bd_we  = 1'b0;
  endtask

  // Issue one request, then watch up to 8 cycles after acceptance (cycle 1 = state after T).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_size = 2'b11;
    lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0; both = 0; busy_ready = 0;
    rd_addr = '0; wr_data = '0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_MemRead) begin nrd++; rd_cyc = c; rd_addr = mem_Address; end
      if (mem_MemWrite) begin nwr++; wr_cyc = c; wr_data = mem_WriteData; end
      if (mem_MemRead && mem_MemWrite) both++;
      if (req_ready) busy_ready++;
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_error; end
    end
    @(negedge clk);
    after_valid = resp_valid;
    after_ready = req_ready;
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] exp);
    run_req(1'b0, sz, sg, a, 32'h0);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic bad_req(input string tag, input logic [1:0] sz, input logic [31:0] a);
    run_req(1'b0, sz, 1'b0, a, 32'h0);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_strobes"}, 32'(nrd + nwr), 32'd0);
    check({tag, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    int          wc0, bad;
    logic [7:0]  rdy, rv, wrv, rdv;
    logic [31:0] b2b_rdata, b2b_wdata;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", 32'(resp_error), 32'd0);
    check("rst_strobes", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("rst_address", mem_Address, 32'h0);
    check("rst_wdata", mem_WriteData, 32'h0);

    poke(13'd4, 32'h8899_AABB);
    poke(13'd5, 32'h0);
    poke(13'h1FFF, 32'h1357_9BDF);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_nrd", 32'(nrd), 32'd1);
    check("lw_rd_cyc", 32'(rd_cyc), 32'd1);
    check("lw_addr", rd_addr, 32'h4);
    check("lw_nwr", 32'(nwr), 32'd0);
    check("lw_rdata", rdata, 32'h8899_AABB);
    check("lw_err", 32'(err), 32'd0);
    check("lw_busy_ready", 32'(busy_ready), 32'd0);
    check("lw_pulse", 32'(after_valid), 32'd0);
    check("lw_ready_after", 32'(after_ready), 32'd1);

    load("lb_s", 2'b00, 1'b1, 32'h13, 32'hFFFF_FF88);
    load("lbu", 2'b00, 1'b0, 32'h13, 32'h0000_0088);
    load("lb_s_pos", 2'b00, 1'b1, 32'h10, 32'hFFFF_FFBB);
    load("lh_s", 2'b01, 1'b1, 32'h10, 32'hFFFF_AABB);
    load("lhu", 2'b01, 1'b0, 32'h12, 32'h0000_8899);
    load("lw_last", 2'b10, 1'b0, 32'h7FFC, 32'h1357_9BDF);

    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56CC);
    check("sb_rd_cyc", 32'(rd_cyc), 32'd1);
    check("sb_wr_cyc", 32'(wr_cyc), 32'd2);
    check("sb_wdata", wr_data, 32'h8899_CCBB);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rdata", rdata, 32'h0);
    check("sb_both", 32'(both), 32'd0);
    load("lw_after_sb", 2'b10, 1'b0, 32'h10, 32'h8899_CCBB);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_nrd", 32'(nrd), 32'd0);
    check("sw_wr_cyc", 32'(wr_cyc), 32'd1);
    check("sw_wdata", wr_data, 32'hDEAD_BEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_mem", mem[4], 32'hDEAD_BEEF);

    bad_req("lw_mis", 2'b10, 32'h12);
    bad_req("lh_mis", 2'b01, 32'h11);
    bad_req("size11", 2'b11, 32'h10);
    bad_req("lw_oor", 2'b10, 32'h8000);

    // Reset while the read half of a halfword store is in progress.
    wc0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_rd", 32'(mem_MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || !req_ready || mem_MemWrite) bad++;
    end
    check("rst_mid_quiet", 32'(bad), 32'd0);
    check("rst_mid_nowrite", 32'(wr_count - wc0), 32'd0);
    check("rst_mid_mem", mem[4], 32'hDEAD_BEEF);

    // Back-to-back: req_valid held high through LW 0x10 then SW 0x14.
    rdy = '0; rv = '0; wrv = '0; rdv = '0; b2b_rdata = '0; b2b_wdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy[c] = req_ready;
      rv[c]  = resp_valid;
      wrv[c] = mem_MemWrite;
      rdv[c] = mem_MemRead;
      if (c == 2) b2b_rdata = resp_rdata;
      if (mem_MemWrite) b2b_wdata = mem_WriteData;
      if (c == 4) req_valid = 1'b0;
    end
    check("b2b_ready", {27'd0, rdy[5:1]}, 32'h04);
    check("b2b_resp", {27'd0, rv[5:1]}, 32'h12);
    check("b2b_write", {27'd0, wrv[5:1]}, 32'h08);
    check("b2b_read", {27'd0, rdv[5:1]}, 32'h01);
    check("b2b_rdata", b2b_rdata, 32'hDEAD_BEEF);
    check("b2b_wdata", b2b_wdata, 32'hCAFE_F00D);
    check("b2b_mem5", mem[5], 32'hCAFE_F00D);
    check("b2b_mem4", mem[4], 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
